// File: rtl/dct_mac_if.sv
// Handshake bundle between the Q16.16 multiplier, the DCT MAC accumulator
// and the downstream block-buffer writer.
// slave  : the accumulator side (consumes products, produces coefficients).
// master : the environment side (drives products, accepts coefficients).
interface dct_mac_if #(
    parameter int IDX_W = 3
);
    logic [31:0]      prod_in;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out_data;
    logic             out_sat;
    logic [IDX_W-1:0] out_index;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output prod_in, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_index, out_valid
    );

    modport slave (
        input  prod_in, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_index, out_valid
    );
endinterface

// File: rtl/dct_mac_accumulator.sv
// DCT MAC accumulator: sums N_TERMS signed Q16.16 products into an ACC_W-bit
// accumulator, then emits one arithmetically shifted, saturated coefficient
// tagged with a wrapping row index.
// Optional build macro DCT_MAC_ROUND_EN: when defined, the final shift rounds
// half toward +infinity; otherwise it truncates toward -infinity.
module dct_mac_accumulator #(
    parameter int N_TERMS   = 8,
    parameter int N_COEFS   = 8,
    parameter int IDX_W     = 3,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 0
) (
    input logic      clk,
    input logic      rst,
    dct_mac_if.slave bus
);
    localparam int CNT_W = $clog2(N_TERMS);

    // Half an output LSB at the pre-shift scale; zero when no shift is applied.
    localparam logic [ACC_W:0] ROUND_BIAS = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  cnt;
    logic        [31:0]       out_data_q;
    logic                     out_sat_q;
    logic        [IDX_W-1:0]  out_index_q;

    logic                     accept;
    logic                     last_term;
    logic signed [ACC_W-1:0]  sum;
    logic        [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    shifted;
    logic                     fits;
    logic        [31:0]       final_data;

    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_index = out_index_q;

    // Datapath: running sum including the current product, then scale and clip.
    always_comb begin
        sum = acc + {{(ACC_W-32){bus.prod_in[31]}}, bus.prod_in};
`ifdef DCT_MAC_ROUND_EN
        // One guard bit above ACC_W keeps the bias add from wrapping.
        rounded = {sum[ACC_W-1], sum} + ROUND_BIAS;
`else
        rounded = {sum[ACC_W-1], sum};
`endif
        shifted = $signed(rounded) >>> OUT_SHIFT;
        // The value fits in 32 bits when every bit from 31 upward is a copy of the sign.
        fits    = (shifted[ACC_W:31] == '0) || (shifted[ACC_W:31] == '1);
        if (fits) begin
            final_data = shifted[31:0];
        end else if (shifted[ACC_W]) begin
            final_data = 32'h8000_0000;
        end else begin
            final_data = 32'h7FFF_FFFF;
        end
    end

    // Next state and handshake outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        last_term     = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                last_term    = (cnt == CNT_W'(N_TERMS - 1));
                if (accept && last_term) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // State register, accumulator, term counter and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_index_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (last_term) begin
                    out_data_q <= final_data;
                    out_sat_q  <= ~fits;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                out_index_q <= (out_index_q == IDX_W'(N_COEFS - 1)) ? '0 : out_index_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dct_mac_accumulator.sv
// Scoreboard bench for dct_mac_accumulator. Two instances: dut0 with
// OUT_SHIFT=0 and dut3 with OUT_SHIFT=3. Stimulus pushes expected
// coefficients into per-instance queues; monitors pop on each handshake.
module tb_dct_mac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_mac_if #(.IDX_W(3)) if0 ();
    dct_mac_if #(.IDX_W(3)) if3 ();

    dct_mac_accumulator #(.N_TERMS(8), .N_COEFS(8), .IDX_W(3), .ACC_W(40), .OUT_SHIFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    dct_mac_accumulator #(.N_TERMS(8), .N_COEFS(8), .IDX_W(3), .ACC_W(40), .OUT_SHIFT(3))
        dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    typedef struct {
        logic [31:0] data;
        logic        sat;
        logic [2:0]  idx;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t m0, m3;
    int   idx0 = 0, idx3 = 0;
    int   n_cmp = 0, n_err = 0;

    logic rdy0 = 1'b1, rdy3 = 1'b1, rand_rdy = 1'b0, rnd_bit = 1'b1;
    assign if0.out_ready = rand_rdy ? rnd_bit : rdy0;
    assign if3.out_ready = rdy3;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    task automatic push(input int sel, input logic [31:0] data, input logic sat);
        exp_t e;
        e.data = data;
        e.sat  = sat;
        if (sel == 0) begin
            e.idx = 3'(idx0);
            idx0  = (idx0 + 1) % 8;
            q0.push_back(e);
        end else begin
            e.idx = 3'(idx3);
            idx3  = (idx3 + 1) % 8;
            q3.push_back(e);
        end
    endtask

    // Presents one product and returns 1 time unit after the edge that accepted it.
    task automatic send(input int sel, input logic [31:0] v);
        int t = 0;
        @(negedge clk);
        if (sel == 0) begin if0.in_valid = 1'b1; if0.prod_in = v; end
        else          begin if3.in_valid = 1'b1; if3.prod_in = v; end
        while (((sel == 0) ? if0.in_ready : if3.in_ready) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail("send_timeout");
        @(posedge clk);
        #1;
        if (sel == 0) if0.in_valid = 1'b0;
        else          if3.in_valid = 1'b0;
    endtask

    task automatic drain(input int sel);
        int t = 0;
        while (((sel == 0) ? q0.size() : q3.size()) != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idx0 = 0;
        idx3 = 0;
    endtask

    // Independent reference: 64-bit sum, optional half-up bias, floor shift, clamp.
    function automatic logic [32:0] ref_coef(input longint s, input int sh);
        longint r = s;
`ifdef DCT_MAC_ROUND_EN
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
        r = r >>> sh;
        if (r > 64'sh7FFF_FFFF)        return {1'b1, 32'h7FFF_FFFF};
        else if (r < -64'sh8000_0000)  return {1'b1, 32'h8000_0000};
        else                           return {1'b0, 32'(r)};
    endfunction

    always @(negedge clk) begin
        if (!rst && if0.out_valid && if0.out_ready) begin
            if (q0.size() == 0) fail("dut0_unexpected_output");
            else begin
                m0 = q0.pop_front();
                check("dut0_data", if0.out_data, m0.data);
                check("dut0_sat", 32'(if0.out_sat), 32'(m0.sat));
                check("dut0_index", 32'(if0.out_index), 32'(m0.idx));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if3.out_valid && if3.out_ready) begin
            if (q3.size() == 0) fail("dut3_unexpected_output");
            else begin
                m3 = q3.pop_front();
                check("dut3_data", if3.out_data, m3.data);
                check("dut3_sat", 32'(if3.out_sat), 32'(m3.sat));
                check("dut3_index", 32'(if3.out_index), 32'(m3.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] p;
        logic [32:0] r;
        longint      s;

        if0.in_valid = 1'b0; if0.prod_in = '0;
        if3.in_valid = 1'b0; if3.prod_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_data", if0.out_data, 32'h0);
        check("rst_out_sat", 32'(if0.out_sat), 32'h0);
        check("rst_out_index", 32'(if0.out_index), 32'h0);
        check("rst_out_valid", 32'(if0.out_valid), 32'h0);
        check("rst_in_ready", 32'(if0.in_ready), 32'h1);

        // 1: eight 1.0 products -> 8.0, valid one cycle after last accept
        push(0, 32'h0008_0000, 1'b0);
        for (int i = 0; i < 7; i++) send(0, 32'h0001_0000);
        check("t1_valid_before_last", 32'(if0.out_valid), 32'h0);
        send(0, 32'h0001_0000);
        check("t1_valid_after_last", 32'(if0.out_valid), 32'h1);
        drain(0);

        // 2: positive and negative saturation
        push(0, 32'h7FFF_FFFF, 1'b1);
        for (int i = 0; i < 8; i++) send(0, 32'h7FFF_FFFF);
        push(0, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 8; i++) send(0, 32'h8000_0000);
        drain(0);

        // 3: OUT_SHIFT=3 truncation vs rounding, sums +12 and -12
`ifdef DCT_MAC_ROUND_EN
        push(1, 32'h0000_0002, 1'b0);
`else
        push(1, 32'h0000_0001, 1'b0);
`endif
        for (int i = 0; i < 8; i++) send(1, (i < 4) ? 32'd3 : 32'd0);
`ifdef DCT_MAC_ROUND_EN
        push(1, 32'hFFFF_FFFF, 1'b0);
`else
        push(1, 32'hFFFF_FFFE, 1'b0);
`endif
        for (int i = 0; i < 8; i++) send(1, (i < 4) ? 32'hFFFF_FFFD : 32'd0);
        drain(1);

        // 4: backpressure for 5 cycles in HOLD with a product waiting
        rdy0 = 1'b0;
        push(0, 32'h0000_0800, 1'b0);
        for (int i = 0; i < 8; i++) send(0, 32'h0000_0100);
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.prod_in  = 32'h0000_0010;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(if0.out_valid), 32'h1);
            check("t4_hold_in_ready", 32'(if0.in_ready), 32'h0);
            check("t4_hold_data", if0.out_data, 32'h0000_0800);
            check("t4_hold_index", 32'(if0.out_index), 32'h3);
            @(negedge clk);
        end
        push(0, 32'h0000_0080, 1'b0);
        @(posedge clk);
        #1 rdy0 = 1'b1;
        for (int i = 0; i < 8; i++) send(0, 32'h0000_0010);
        drain(0);

        // 5: reset mid-accumulation discards partial sum and index
        for (int i = 0; i < 3; i++) send(0, 32'h0001_0000);
        reset_pulse();
        check("t5_rst_index", 32'(if0.out_index), 32'h0);
        check("t5_rst_valid", 32'(if0.out_valid), 32'h0);
        check("t5_rst_in_ready", 32'(if0.in_ready), 32'h1);
        push(0, 32'h0008_0000, 1'b0);
        for (int i = 0; i < 8; i++) send(0, 32'h0001_0000);
        drain(0);

        // 6: nine coefficients, random gaps and random out_ready
        reset_pulse();
        rand_rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            logic [31:0] prods[8];
            s = 0;
            for (int i = 0; i < 8; i++) begin
                if (c % 3 == 0) p = $urandom;
                else            p = 32'($urandom_range(0, 65535)) - 32'd32768;
                prods[i] = p;
                s += longint'($signed(p));
            end
            r = ref_coef(s, 0);
            push(0, r[31:0], r[32]);
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send(0, prods[i]);
            end
        end
        drain(0);
        rand_rdy = 1'b0;

        check("end_q0_empty", 32'(q0.size()), 32'h0);
        check("end_q3_empty", 32'(q3.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
